// File: rtl/i2c_target_if_if.sv
// Bus-side bundle for the I2C target: oversampled pins plus the
// byte-level handshake toward user logic.
`timescale 1ns/1ps
interface i2c_target_if_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       stop_det;

    modport slave (
        input  scl_in,
        input  sda_in,
        input  tx_data,
        output sda_oe,
        output rx_data,
        output rx_valid,
        output tx_req,
        output busy,
        output stop_det
    );

    modport master (
        output scl_in,
        output sda_in,
        output tx_data,
        input  sda_oe,
        input  rx_data,
        input  rx_valid,
        input  tx_req,
        input  busy,
        input  stop_det
    );
endinterface

// File: rtl/i2c_target_if.sv
// I2C target, 7-bit addressing: oversampled SCL/SDA, START/STOP
// detection, address match, open-drain SDA only, byte handshake.
`timescale 1ns/1ps
module i2c_target_if #(
    parameter logic [6:0] OWN_ADDR = 7'h50
) (
    input logic          clk,
    input logic          rst,
    i2c_target_if_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } state_t;

    state_t     state;
    logic [1:0] scl_s;
    logic [1:0] sda_s;
    logic       scl_q;
    logic       sda_q;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [7:0] tx_shift;
    logic       rw;
    logic       ack_on;
    logic       rd_load;

    logic scl;
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_c;
    logic stop_c;

    // Idle bus is high, so the synchronizers reset to 1 to avoid
    // phantom edges when reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_s <= {scl_s[0], bus.scl_in};
            sda_s <= {sda_s[0], bus.sda_in};
            scl_q <= scl_s[1];
            sda_q <= sda_s[1];
        end
    end

    assign scl      = scl_s[1];
    assign sda      = sda_s[1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start_c  = scl & scl_q & sda_q & ~sda;
    assign stop_c   = scl & scl_q & ~sda_q & sda;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            shift        <= 7'd0;
            tx_shift     <= 8'd0;
            rw           <= 1'b0;
            ack_on       <= 1'b0;
            rd_load      <= 1'b0;
            bus.sda_oe   <= 1'b0;
            bus.rx_data  <= 8'd0;
            bus.rx_valid <= 1'b0;
            bus.tx_req   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.stop_det <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            bus.tx_req   <= 1'b0;
            bus.stop_det <= 1'b0;
            if (bus.tx_req) begin
                tx_shift <= bus.tx_data;
            end
            if (stop_c) begin
                state        <= IDLE;
                bit_cnt      <= 3'd0;
                bus.sda_oe   <= 1'b0;
                bus.busy     <= 1'b0;
                bus.stop_det <= 1'b1;
            end else if (start_c) begin
                state      <= ADDR;
                bit_cnt    <= 3'd0;
                bus.sda_oe <= 1'b0;
                bus.busy   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[5:0], sda};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift == OWN_ADDR) begin
                                    state      <= ADDR_ACK;
                                    bus.busy   <= 1'b1;
                                    rw         <= sda;
                                    bus.tx_req <= sda;
                                    ack_on     <= 1'b0;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                    // First fall starts the ACK, the second ends it.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                bus.sda_oe <= 1'b1;
                                ack_on     <= 1'b1;
                            end else if (rw) begin
                                state      <= RD_DATA;
                                bus.sda_oe <= ~tx_shift[7];
                                rd_load    <= 1'b0;
                            end else begin
                                state      <= WR_DATA;
                                bus.sda_oe <= 1'b0;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[5:0], sda};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                bus.rx_data  <= {shift, sda};
                                bus.rx_valid <= 1'b1;
                                state        <= WR_ACK;
                                ack_on       <= 1'b0;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                bus.sda_oe <= 1'b1;
                                ack_on     <= 1'b1;
                            end else begin
                                bus.sda_oe <= 1'b0;
                                state      <= WR_DATA;
                            end
                        end
                    end
                    // bit_cnt counts rises; ~bit_cnt is the next bit index.
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (scl_fall) begin
                            if (rd_load) begin
                                bus.sda_oe <= ~tx_shift[7];
                                rd_load    <= 1'b0;
                            end else if (bit_cnt == 3'd0) begin
                                bus.sda_oe <= 1'b0;
                                state      <= RD_ACK;
                            end else begin
                                bus.sda_oe <= ~tx_shift[~bit_cnt];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda) begin
                                bus.tx_req <= 1'b1;
                                state      <= RD_DATA;
                                rd_load    <= 1'b1;
                            end else begin
                                state      <= IDLE;
                                bus.sda_oe <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_if.sv
// Directed bench for i2c_target_if: bit-banged initiator, wired-AND
// SDA, scoreboard queues for written and read bytes.
`timescale 1ns/1ps
module tb_i2c_target_if;

    localparam time Q = 50ns;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #5 clk = ~clk;

    i2c_target_if_if bus ();

    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_target_if #(.OWN_ADDR(7'h50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int stop_cnt = 0;
    bit oe_seen = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] rd_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid) begin
                rx_cnt++;
                if (rx_q.size() == 0)
                    chk("rx_unexpected", 32'd1, 32'd0);
                else
                    chk("rx_data", 32'(bus.rx_data), 32'(rx_q.pop_front()));
            end
            if (bus.tx_req) tx_cnt++;
            if (bus.stop_det) stop_cnt++;
            if (bus.sda_oe) oe_seen = 1'b1;
        end
    end

    task automatic clear_counts();
        rx_cnt = 0;
        tx_cnt = 0;
        stop_cnt = 0;
        oe_seen = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic i2c_rstart();
        #Q sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        #Q sda_m = b;
        #Q scl_m = 1'b1;
        #Q s = bus.sda_in;
        #Q scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_bits(output logic [7:0] d);
        logic s;
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            d = {d[6:0], s};
        end
    endtask

    task automatic run_write(input string tag);
        logic ack;
        clear_counts();
        i2c_start();
        write_byte(8'hA0, ack);
        chk({tag, "_addr_ack"}, 32'(ack), 32'd0);
        chk({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
        rx_q.push_back(8'h3C);
        write_byte(8'h3C, ack);
        chk({tag, "_data_ack"}, 32'(ack), 32'd0);
        chk({tag, "_no_stop_yet"}, 32'(stop_cnt), 32'd0);
        i2c_stop();
        chk({tag, "_rx_cnt"}, 32'(rx_cnt), 32'd1);
        chk({tag, "_rx_q_empty"}, 32'(rx_q.size()), 32'd0);
        chk({tag, "_stop_cnt"}, 32'(stop_cnt), 32'd1);
        chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
        chk({tag, "_tx_cnt"}, 32'(tx_cnt), 32'd0);
    endtask

    initial begin
        logic ack;
        logic s;
        logic [7:0] d;
        bus.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_tx_req", 32'(bus.tx_req), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_stop_det", 32'(bus.stop_det), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: plain write
        run_write("s1");

        // 2: address mismatch
        clear_counts();
        i2c_start();
        write_byte(8'hA4, ack);
        chk("s2_addr_nack", 32'(ack), 32'd1);
        write_byte(8'h55, ack);
        chk("s2_data_nack", 32'(ack), 32'd1);
        chk("s2_busy", 32'(bus.busy), 32'd0);
        i2c_stop();
        chk("s2_oe_never", 32'(oe_seen), 32'd0);
        chk("s2_rx_cnt", 32'(rx_cnt), 32'd0);
        chk("s2_tx_cnt", 32'(tx_cnt), 32'd0);

        // 3: two-byte read, ACK then NACK
        clear_counts();
        bus.tx_data = 8'h96;
        rd_q.push_back(8'h96);
        i2c_start();
        write_byte(8'hA1, ack);
        chk("s3_addr_ack", 32'(ack), 32'd0);
        read_bits(d);
        chk("s3_rd0", 32'(d), 32'(rd_q.pop_front()));
        bus.tx_data = 8'h5A;
        rd_q.push_back(8'h5A);
        bit_xfer(1'b0, s);
        read_bits(d);
        chk("s3_rd1", 32'(d), 32'(rd_q.pop_front()));
        bit_xfer(1'b1, s);
        #Q;
        chk("s3_oe_released", 32'(bus.sda_oe), 32'd0);
        chk("s3_busy_held", 32'(bus.busy), 32'd1);
        i2c_stop();
        chk("s3_tx_cnt", 32'(tx_cnt), 32'd2);
        chk("s3_stop_cnt", 32'(stop_cnt), 32'd1);
        chk("s3_busy_off", 32'(bus.busy), 32'd0);

        // 4: write, repeated START, read
        clear_counts();
        i2c_start();
        write_byte(8'hA0, ack);
        chk("s4_addr_ack", 32'(ack), 32'd0);
        rx_q.push_back(8'h11);
        write_byte(8'h11, ack);
        chk("s4_data_ack", 32'(ack), 32'd0);
        i2c_rstart();
        chk("s4_rx_cnt", 32'(rx_cnt), 32'd1);
        chk("s4_busy_sr", 32'(bus.busy), 32'd0);
        bus.tx_data = 8'hC3;
        rd_q.push_back(8'hC3);
        write_byte(8'hA1, ack);
        chk("s4_raddr_ack", 32'(ack), 32'd0);
        read_bits(d);
        chk("s4_rd", 32'(d), 32'(rd_q.pop_front()));
        bit_xfer(1'b1, s);
        chk("s4_no_stop", 32'(stop_cnt), 32'd0);
        i2c_stop();
        chk("s4_tx_cnt", 32'(tx_cnt), 32'd1);
        chk("s4_stop_cnt", 32'(stop_cnt), 32'd1);

        // 5: reset while the target pulls SDA low
        clear_counts();
        bus.tx_data = 8'h00;
        i2c_start();
        write_byte(8'hA1, ack);
        for (int i = 0; i < 20; i++) begin
            if (bus.sda_oe) break;
            @(negedge clk);
        end
        chk("s5_oe_before", 32'(bus.sda_oe), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("s5_oe_async", 32'(bus.sda_oe), 32'd0);
        chk("s5_busy_rst", 32'(bus.busy), 32'd0);
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run_write("s5");

        // 6: STOP inside a data byte
        clear_counts();
        i2c_start();
        write_byte(8'hA0, ack);
        chk("s6_addr_ack", 32'(ack), 32'd0);
        bit_xfer(1'b1, s);
        bit_xfer(1'b0, s);
        bit_xfer(1'b1, s);
        bit_xfer(1'b0, s);
        i2c_stop();
        chk("s6_rx_cnt", 32'(rx_cnt), 32'd0);
        chk("s6_stop_cnt", 32'(stop_cnt), 32'd1);
        chk("s6_state_idle", 32'(dut.state), 32'd0);
        chk("s6_busy", 32'(bus.busy), 32'd0);
        chk("s6_rx_q_empty", 32'(rx_q.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
